fetch_queue: RTL and testbench

Parametrised successor to the single-register fetch stage: holds the program counter, reads the internal instruction memory once per cycle and pushes {pc, instr} into a DEPTH-entry FIFO that decouples fetch from decode. Decode consumes entries with a valid/ready handshake instead of a global enable. A redirect from the memory stage flushes the queue and reloads the PC. The block sits between the PC/instruction memory and the DECODE stage.

---
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_queue.sv | 80 ++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: redirect input, decode handshake and head-entry payload.
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             PCSrcM;
    logic [XLEN-1:0]  pcM;
    logic             readyD;
    logic [XLEN-1:0]  pcD;
    logic [XLEN-1:0]  instrD;
    logic             validD;
    logic [CNT_W-1:0] countF;

    // Memory/decode side: issues redirects and accepts head entries
    modport master (
        output PCSrcM, pcM, readyD,
        input  pcD, instrD, validD, countF
    );

    // Fetch queue side
    modport slave (
        input  PCSrcM, pcM, readyD,
        output pcD, instrD, validD, countF
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry {pc, instr} FIFO decoupling fetch from decode.
module fetch_queue #(
    parameter int unsigned   XLEN       = 32,
    parameter int unsigned   IMEM_POWER = 18,
    parameter int unsigned   DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.slave fq
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned MEM_SIZE = 2 ** IMEM_POWER;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0]       RAM [0:MEM_SIZE-1];
    logic [XLEN-1:0]       pc;
    entry_t                slots [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  valid;

    logic [IMEM_POWER-1:0] index_c;
    logic                  pop_c;
    logic                  push_c;
    logic [CNT_W-1:0]      count_next_c;

    // Memory index, handshake decode and next occupancy
    always_comb begin
        index_c      = pc[IMEM_POWER+1:2];
        pop_c        = valid & fq.readyD;
        push_c       = (count < CNT_W'(DEPTH)) | pop_c;
        count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Control state: reset beats redirect, redirect beats push/pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= 1'b0;
        end else if (fq.PCSrcM) begin
            pc    <= fq.pcM & ~XLEN'(3);
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= 1'b0;
        end else begin
            if (push_c) begin
                pc   <= pc + XLEN'(4);
                tail <= tail + PTR_W'(1);
            end
            if (pop_c) begin
                head <= head + PTR_W'(1);
            end
            count <= count_next_c;
            valid <= (count_next_c != '0);
        end
    end

    // Queue storage; contents are don't-care after reset or flush
    always_ff @(posedge clk) begin
        if (reset && !fq.PCSrcM && push_c) begin
            slots[tail] <= '{pc: pc, instr: RAM[index_c]};
        end
    end

    assign fq.pcD    = slots[head].pc;
    assign fq.instrD = slots[head].instr;
    assign fq.validD = valid;
    assign fq.countF = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, hand sequences, random vs queue model.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic        rst;
        logic        pcsrc;
        logic [31:0] pcm;
        logic        ready;
        logic        ev;
        int          ec;
        logic [31:0] epc;
        logic [31:0] einstr;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_cmp;
    int   n_bad;

    fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) ifa ();
    fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) ifb ();

    fetch_queue #(.XLEN(32), .IMEM_POWER(8), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .fq    (ifa.slave)
    );

    fetch_queue #(.XLEN(32), .IMEM_POWER(4), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .fq    (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of fetched (pc, instr) pairs plus a fetch pc
    logic [31:0] mq_pc [$];
    logic [31:0] mq_in [$];
    logic [31:0] m_pc;

    function automatic logic [31:0] ram_a(input logic [31:0] addr);
        return 32'h1000 + ((addr >> 2) & 32'hFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_a(input logic r, input logic pcs, input logic [31:0] pcm, input logic rdy);
        bit          pop;
        bit          push;
        int          sz;
        logic [31:0] tmp;
        rst_a      = r;
        ifa.PCSrcM = pcs;
        ifa.pcM    = pcm;
        ifa.readyD = rdy;
        sz   = mq_pc.size();
        pop  = (sz != 0) && (rdy == 1'b1);
        push = (sz < int'(DEPTH)) || pop;
        if (r == 1'b0) begin
            mq_pc.delete();
            mq_in.delete();
            m_pc = 32'h0;
        end else if (pcs == 1'b1) begin
            mq_pc.delete();
            mq_in.delete();
            m_pc = {pcm[31:2], 2'b00};
        end else begin
            if (pop) begin
                tmp = mq_pc.pop_front();
                tmp = mq_in.pop_front();
            end
            if (push) begin
                mq_pc.push_back(m_pc);
                mq_in.push_back(ram_a(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        check("model_valid", 32'(ifa.validD), 32'(mq_pc.size() != 0));
        check("model_count", 32'(ifa.countF), 32'(mq_pc.size()));
        check("model_fetch_pc", dut_a.pc, m_pc);
        if (mq_pc.size() != 0) begin
            check("model_pcD", ifa.pcD, mq_pc[0]);
            check("model_instrD", ifa.instrD, mq_in[0]);
        end
    endtask

    task automatic step_b(input logic r, input logic pcs, input logic [31:0] pcm, input logic rdy);
        rst_b      = r;
        ifb.PCSrcM = pcs;
        ifb.pcM    = pcm;
        ifb.readyD = rdy;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [16];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.PCSrcM = 1'b0; ifa.pcM = '0; ifa.readyD = 1'b0;
        ifb.PCSrcM = 1'b0; ifb.pcM = '0; ifb.readyD = 1'b0;
        for (int i = 0; i < 256; i++) dut_a.RAM[i] = 32'h1000 + 32'(i);
        for (int i = 0; i < 16; i++)  dut_b.RAM[i] = 32'hA000 + 32'(i);

        // Directed vectors: fill to full, pop at full, redirect, reset with redirect
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 0, 32'h0,   32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1, 32'h0,   32'h1000};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 2, 32'h0,   32'h1000};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 3, 32'h0,   32'h1000};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 4, 32'h0,   32'h1000};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 4, 32'h0,   32'h1000};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 4, 32'h4,   32'h1001};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 4, 32'h8,   32'h1002};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 4, 32'h8,   32'h1002};
        tbl[9]  = '{1'b1, 1'b1, 32'h203, 1'b1, 1'b0, 0, 32'h0,   32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1, 32'h200, 32'h1080};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1, 32'h204, 32'h1081};
        tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1, 32'h208, 32'h1082};
        tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 2, 32'h208, 32'h1082};
        tbl[14] = '{1'b0, 1'b1, 32'h40,  1'b0, 1'b0, 0, 32'h0,   32'h0};
        tbl[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1, 32'h0,   32'h1000};

        for (int i = 0; i < 16; i++) begin
            step_a(tbl[i].rst, tbl[i].pcsrc, tbl[i].pcm, tbl[i].ready);
            check($sformatf("tbl%0d_valid", i), 32'(ifa.validD), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_count", i), 32'(ifa.countF), 32'(tbl[i].ec));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_pcD", i), ifa.pcD, tbl[i].epc);
                check($sformatf("tbl%0d_instrD", i), ifa.instrD, tbl[i].einstr);
            end
            if (i == 5 || i == 14) check($sformatf("tbl%0d_fetch_pc", i), dut_a.pc, (i == 5) ? 32'h10 : 32'h0);
        end

        // Reset then stream with readyD held high: no bubbles
        step_a(1'b0, 1'b0, 32'h0, 1'b1);
        check("stream_reset_valid", 32'(ifa.validD), 32'h0);
        for (int k = 0; k < 20; k++) begin
            step_a(1'b1, 1'b0, 32'h0, 1'b1);
            check($sformatf("stream%0d_valid", k), 32'(ifa.validD), 32'h1);
            check($sformatf("stream%0d_pcD", k), ifa.pcD, 32'(4 * k));
            check($sformatf("stream%0d_instrD", k), ifa.instrD, 32'h1000 + 32'(k));
        end

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            step_a(1'($urandom_range(63) != 0), 1'($urandom_range(15) == 0), $urandom,
                   1'($urandom_range(9) < ((i % 200) < 100 ? 7 : 2)));
        end

        // Pc and memory index wrap on the small-memory instance
        step_b(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_reset_valid", 32'(ifb.validD), 32'h0);
        check("wrap_reset_count", 32'(ifb.countF), 32'h0);
        step_b(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        check("wrap_flush_valid", 32'(ifb.validD), 32'h0);
        check("wrap_flush_count", 32'(ifb.countF), 32'h0);
        check("wrap_fetch_pc", dut_b.pc, 32'hFFFF_FFF8);
        step_b(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap0_valid", 32'(ifb.validD), 32'h1);
        check("wrap0_pcD", ifb.pcD, 32'hFFFF_FFF8);
        check("wrap0_instrD", ifb.instrD, 32'hA00E);
        step_b(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap1_pcD", ifb.pcD, 32'hFFFF_FFFC);
        check("wrap1_instrD", ifb.instrD, 32'hA00F);
        step_b(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap2_valid", 32'(ifb.validD), 32'h1);
        check("wrap2_pcD", ifb.pcD, 32'h0);
        check("wrap2_instrD", ifb.instrD, 32'hA000);
        step_b(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap3_pcD", ifb.pcD, 32'h4);
        check("wrap3_instrD", ifb.instrD, 32'hA001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
